// File: rtl/mix_columns_iter_if.sv
// Handshake bundle for mix_columns_iter: valid/ready input state with mode bit,
// valid/ready registered result, plus a busy flag for round control.
interface mix_columns_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic         in_inv;
  logic [127:0] in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out;
  logic         busy;

  modport master (
    output in_valid, in_inv, in, out_ready,
    input  in_ready, out_valid, out, busy
  );

  modport slave (
    input  in_valid, in_inv, in, out_ready,
    output in_ready, out_valid, out, busy
  );
endinterface

// File: rtl/mix_columns_iter.sv
// Iterative AES (Inv)MixColumns over COLS_PER_CYCLE columns per clock; result valid 4/COLS_PER_CYCLE
// cycles after accept; input stalls outside IDLE and the result is held while out_ready is low.
module mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 1,
  parameter bit INV_EN         = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  mix_columns_iter_if.slave bus
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // One column, element r is the byte of row r.
  typedef logic [3:0][7:0] col_t;

  // A step of 4 truncates to 0, so the single RUN cycle wraps straight to DONE.
  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);

  state_e       state_q, state_d;
  logic [1:0]   col_cnt_q;
  logic [1:0]   col_cnt_nxt;
  logic [127:0] src_q;
  logic [127:0] out_q;
  logic [127:0] out_d;
  logic         inv_q;
  logic         load;
  logic         step;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic col_t get_col(input logic [127:0] s, input logic [1:0] c);
    col_t a;
    a = '0;
    for (int r = 0; r < 4; r++) begin
      a[r] = s[127 - 32*r - 8*int'(c) -: 8];
    end
    return a;
  endfunction

  function automatic col_t mix_fwd(input col_t a);
    col_t o;
    o[0] = xtime(a[0] ^ a[1]) ^ a[1] ^ a[2] ^ a[3];
    o[1] = xtime(a[1] ^ a[2]) ^ a[0] ^ a[2] ^ a[3];
    o[2] = xtime(a[2] ^ a[3]) ^ a[0] ^ a[1] ^ a[3];
    o[3] = xtime(a[3] ^ a[0]) ^ a[0] ^ a[1] ^ a[2];
    return o;
  endfunction

  // InvMixColumns is a cheap pre-mix followed by the forward matrix, so both modes
  // share one forward datapath.
  function automatic col_t mix_col(input col_t a, input logic inv);
    col_t       b;
    logic [7:0] u;
    logic [7:0] v;
    b = a;
    u = '0;
    v = '0;
    if (INV_EN && inv) begin
      u    = xtime(xtime(a[0] ^ a[2]));
      v    = xtime(xtime(a[1] ^ a[3]));
      b[0] = a[0] ^ u;
      b[1] = a[1] ^ v;
      b[2] = a[2] ^ u;
      b[3] = a[3] ^ v;
    end
    return mix_fwd(b);
  endfunction

  assign col_cnt_nxt = col_cnt_q + STEP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    load          = 1'b0;
    step          = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        bus.busy = 1'b1;
        step     = 1'b1;
        if (col_cnt_nxt == 2'd0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  col_t       lane_res [COLS_PER_CYCLE];
  logic [1:0] lane_col [COLS_PER_CYCLE];

  for (genvar l = 0; l < COLS_PER_CYCLE; l++) begin : g_lane
    assign lane_col[l] = col_cnt_q + 2'(l);
    assign lane_res[l] = mix_col(get_col(src_q, lane_col[l]), inv_q);
  end

  // Only the columns handled this cycle are replaced; the rest keep their old bytes.
  always_comb begin
    out_d = out_q;
    for (int l = 0; l < COLS_PER_CYCLE; l++) begin
      for (int r = 0; r < 4; r++) begin
        out_d[127 - 32*r - 8*int'(lane_col[l]) -: 8] = lane_res[l][r];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q     <= '0;
      out_q     <= '0;
      inv_q     <= 1'b0;
      col_cnt_q <= 2'd0;
    end else if (load) begin
      src_q     <= bus.in;
      inv_q     <= bus.in_inv & INV_EN;
      col_cnt_q <= 2'd0;
    end else if (step) begin
      out_q     <= out_d;
      col_cnt_q <= col_cnt_nxt;
    end
  end

  assign bus.out = out_q;

endmodule

// File: tb/tb_mix_columns_iter.sv
// Bench for mix_columns_iter: four configurations driven with directed vectors and
// compared every cycle against a GF(2^8) matrix model of MixColumns/InvMixColumns.
`timescale 1ns/1ps
module tb_mix_columns_iter;

  localparam logic [127:0] VEC_A = 128'hdbf201c6_130a01c6_532201c6_455c01c6;
  localparam logic [127:0] MIX_A = 128'h8e9f01c6_4ddc01c6_a15801c6_bc9d01c6;
  localparam logic [127:0] VEC_B = 128'hd4d4d4d4_bfbfbfbf_5d5d5d5d_30303030;
  localparam logic [127:0] MIX_B = 128'h04040404_66666666_81818181_e5e5e5e5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]        iv, iinv, ordy;
  logic [3:0]        irdy, ovld, obusy;
  logic [3:0][127:0] idat, odat;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  // Circulant matrix product: row r of the matrix is the base row rotated right by r.
  function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
    logic [7:0]   base [4];
    logic [7:0]   acc;
    logic [127:0] o;
    if (inv) begin
      base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
    end else begin
      base[0] = 8'h02; base[1] = 8'h03; base[2] = 8'h01; base[3] = 8'h01;
    end
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(base[(k - r + 4) % 4], s[127 - 32*k - 8*c -: 8]);
        o[127 - 32*r - 8*c -: 8] = acc;
      end
    end
    return o;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : u
    localparam int C  = (g == 1) ? 2 : ((g == 2) ? 4 : 1);
    localparam bit IE = (g != 3);
    localparam int K  = 4 / C;

    mix_columns_iter_if ifc();
    assign ifc.in_valid  = iv[g];
    assign ifc.in_inv    = iinv[g];
    assign ifc.in        = idat[g];
    assign ifc.out_ready = ordy[g];
    assign irdy[g]  = ifc.in_ready;
    assign ovld[g]  = ifc.out_valid;
    assign obusy[g] = ifc.busy;
    assign odat[g]  = ifc.out;

    mix_columns_iter #(.COLS_PER_CYCLE(C), .INV_EN(IE)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (ifc)
    );

    bit           act = 1'b0;
    int           age = 0;
    logic [127:0] res = '0;
    logic [127:0] held = '0;

    always @(negedge clk) begin
      if (!rst_n) begin
        act  = 1'b0;
        age  = 0;
        held = '0;
      end
      if (!act) begin
        check($sformatf("u%0d idle flags", g), 128'({irdy[g], ovld[g], obusy[g]}), 128'(3'b100));
        check($sformatf("u%0d idle out", g), odat[g], held);
      end else if (age < K) begin
        check($sformatf("u%0d run flags", g), 128'({irdy[g], ovld[g], obusy[g]}), 128'(3'b001));
      end else begin
        check($sformatf("u%0d done flags", g), 128'({irdy[g], ovld[g], obusy[g]}), 128'(3'b011));
        check($sformatf("u%0d done out", g), odat[g], res);
      end
      if (rst_n) begin
        if (!act) begin
          if (iv[g]) begin
            act = 1'b1;
            age = 0;
            res = model(idat[g], iinv[g] & IE);
          end
        end else if (age >= K && ordy[g]) begin
          act  = 1'b0;
          held = res;
        end else begin
          age++;
        end
      end
    end
  end

  task automatic send(input int n, input logic [127:0] d, input logic inv);
    bit ok;
    ok = 1'b0;
    idat[n] = d;
    iinv[n] = inv;
    iv[n]   = 1'b1;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (irdy[n]) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    iv[n] = 1'b0;
    if (!ok) begin
      n_chk++;
      $display("FAIL u%0d accept: in_ready never high within 30 cycles", n);
    end
  endtask

  task automatic wait_valid(input int n, output int lat);
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (ovld[n]) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) begin
      n_chk++;
      $display("FAIL u%0d out_valid: not seen within 30 cycles", n);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int acc[$];
    iv = '0; iinv = '0; ordy = '0; idat = '0;

    check("model fwd A", model(VEC_A, 1'b0), MIX_A);
    check("model inv A", model(MIX_A, 1'b1), VEC_A);
    check("model fwd B", model(VEC_B, 1'b0), MIX_B);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      check($sformatf("reset u%0d out", n), odat[n], 128'h0);
      check($sformatf("reset u%0d flags", n), 128'({irdy[n], ovld[n], obusy[n]}), 128'(3'b100));
    end

    // Forward, one column per cycle, then hold the result under backpressure.
    send(0, VEC_A, 1'b0);
    wait_valid(0, lat);
    check("u0 fwd latency", 128'(lat), 128'd4);
    check("u0 fwd result", odat[0], MIX_A);
    for (int i = 0; i < 10; i++) begin
      iv[0]   = i[0];
      idat[0] = VEC_B;
      @(negedge clk);
      check("bp flags", 128'({irdy[0], ovld[0]}), 128'(2'b01));
      check("bp out", odat[0], MIX_A);
      @(posedge clk);
      #1;
    end
    iv[0]   = 1'b0;
    ordy[0] = 1'b1;
    @(posedge clk);
    #1;
    check("bp release flags", 128'({irdy[0], ovld[0], obusy[0]}), 128'(3'b100));
    check("bp release out kept", odat[0], MIX_A);
    ordy[0] = 1'b0;

    // Inverse, all four columns in one cycle.
    send(2, MIX_A, 1'b1);
    wait_valid(2, lat);
    check("u2 inv latency", 128'(lat), 128'd1);
    check("u2 inv result", odat[2], VEC_A);
    ordy[2] = 1'b1;
    @(posedge clk);
    #1 ordy[2] = 1'b0;

    // Inverse hardware absent: mode bit must be ignored.
    send(3, VEC_A, 1'b1);
    wait_valid(3, lat);
    check("u3 fwd-only latency", 128'(lat), 128'd4);
    check("u3 fwd-only result", odat[3], MIX_A);
    ordy[3] = 1'b1;
    @(posedge clk);
    #1 ordy[3] = 1'b0;

    // Reset after two RUN cycles, then a fresh transaction.
    send(0, VEC_A, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrun reset out", odat[0], 128'h0);
    check("midrun reset flags", 128'({irdy[0], ovld[0], obusy[0]}), 128'(3'b100));
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(0, VEC_B, 1'b0);
    wait_valid(0, lat);
    check("post-reset latency", 128'(lat), 128'd4);
    check("post-reset result", odat[0], MIX_B);
    ordy[0] = 1'b1;
    @(posedge clk);
    #1 ordy[0] = 1'b0;

    // Back-to-back, two columns per cycle, valid and ready tied high.
    idat[1] = VEC_B;
    iinv[1] = 1'b0;
    ordy[1] = 1'b1;
    iv[1]   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (irdy[1]) acc.push_back(cyc);
      if (ovld[1]) check("b2b out", odat[1], MIX_B);
      @(posedge clk);
      #1;
    end
    iv[1] = 1'b0;
    check("b2b accept count", 128'(acc.size() >= 4), 128'd1);
    for (int i = 1; i < acc.size(); i++) begin
      check($sformatf("b2b spacing %0d", i), 128'(acc[i] - acc[i-1]), 128'd4);
    end

    repeat (8) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
